// File: rtl/multi_key_debounce_if.sv
// Key-pad bundle between the board pins and the debouncer.
// The slave modport is the debouncer side and the master modport is the key source and consumer side.
interface multi_key_debounce_if #(
   parameter int N = 4
);
   logic [N-1:0] in_i;
   logic [N-1:0] level_o;
   logic [N-1:0] press_o;
   logic [N-1:0] release_o;
   logic         any_press_o;

   modport master (
      output in_i,
      input  level_o, press_o, release_o, any_press_o
   );

   modport slave (
      input  in_i,
      output level_o, press_o, release_o, any_press_o
   );
endinterface

// File: rtl/multi_key_debounce.sv
// N-channel key debouncer with registered one-cycle press/release strobes.
// Defining the AUTOREPEAT_EN macro adds a per-channel auto-repeat FSM that re-fires press while a key is held.
module multi_key_debounce #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 8,
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 5
)(
   input  logic                clk,
   input  logic                rst,
   multi_key_debounce_if.slave bus
);

   localparam int              CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (N < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : gBadParams
      $error("multi_key_debounce: parameter out of range");
   end

   logic [N-1:0]            sync1_q, sync2_q;
   logic [N-1:0]            level_q, level_d;
   logic [N-1:0]            press_q, press_d;
   logic [N-1:0]            release_q, release_d;
   logic                    anyPress_q, anyPress_d;
   logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]            rise, fall, repeatPulse;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         level_q    <= '0;
         cnt_q      <= '0;
         press_q    <= '0;
         release_q  <= '0;
         anyPress_q <= 1'b0;
      end else begin
         sync1_q    <= bus.in_i;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         anyPress_q <= anyPress_d;
      end
   end

   // A synchronised sample that disagrees with the level for STABLE_CYCLES cycles flips it; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise    = '0;
      fall    = '0;
      for (int i = 0; i < N; i++) begin
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
            rise[i]    = sync2_q[i];
            fall[i]    = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      press_d    = rise | repeatPulse;
      release_d  = fall;
      anyPress_d = |press_d;
   end

`ifdef AUTOREPEAT_EN
   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_HOLD,
      RPT_REPEAT
   } rptState_e;

   localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W       = $clog2(RPT_MAX);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   rptState_e               rptState_q [N];
   rptState_e               rptState_d [N];
   logic [N-1:0][RPT_W-1:0] rptCnt_q, rptCnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            rptState_q[i] <= RPT_IDLE;
         end
         rptCnt_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            rptState_q[i] <= rptState_d[i];
         end
         rptCnt_q <= rptCnt_d;
      end
   end

   // Checking the next level rather than the current one lets a release win over a repeat due in the same cycle.
   always_comb begin
      rptCnt_d    = rptCnt_q;
      repeatPulse = '0;
      for (int i = 0; i < N; i++) begin
         rptState_d[i] = rptState_q[i];
         if (!level_d[i]) begin
            rptState_d[i] = RPT_IDLE;
            rptCnt_d[i]   = '0;
         end else begin
            case (rptState_q[i])
               RPT_IDLE: begin
                  if (rise[i]) begin
                     rptState_d[i] = RPT_HOLD;
                     rptCnt_d[i]   = '0;
                  end
               end
               RPT_HOLD: begin
                  if (rptCnt_q[i] == DELAY_LAST) begin
                     repeatPulse[i] = 1'b1;
                     rptCnt_d[i]    = '0;
                     rptState_d[i]  = RPT_REPEAT;
                  end else begin
                     rptCnt_d[i] = rptCnt_q[i] + RPT_W'(1);
                  end
               end
               RPT_REPEAT: begin
                  if (rptCnt_q[i] == PERIOD_LAST) begin
                     repeatPulse[i] = 1'b1;
                     rptCnt_d[i]    = '0;
                  end else begin
                     rptCnt_d[i] = rptCnt_q[i] + RPT_W'(1);
                  end
               end
               default: begin
                  rptState_d[i] = RPT_IDLE;
                  rptCnt_d[i]   = '0;
               end
            endcase
         end
      end
   end
`else
   assign repeatPulse = '0;
`endif

   assign bus.level_o     = level_q;
   assign bus.press_o     = press_q;
   assign bus.release_o   = release_q;
   assign bus.any_press_o = anyPress_q;

endmodule
